// File: rtl/ps2_key_sequencer.sv
// PS/2 keyboard host sequencer: reset handshake, LED update commands and scan-code decode.
// Optional build macro PS2_TYPEMATIC_FILTER_EN suppresses auto-repeat make events.
//
// state    | meaning
// INIT_TX  | send 0xFF reset command
// INIT_ACK | await 0xFA for the reset command
// INIT_BAT | await 0xAA self-test pass
// IDLE     | no command in flight, accepts led_req
// LED_TX   | send 0xED set-LED command
// LED_ACK  | await 0xFA for 0xED
// ARG_TX   | send LED bitmap argument
// ARG_ACK  | await 0xFA for the argument
module ps2_key_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 2000000,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       read_data,
  input  logic       busy,
  input  logic       err,
  output logic [7:0] tx_data,
  output logic       write_data,
  input  logic       led_req,
  input  logic [2:0] led_val,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic       init_done,
  output logic       cmd_busy,
  output logic       cmd_err
);

  typedef enum logic [2:0] {
    INIT_TX, INIT_ACK, INIT_BAT, IDLE, LED_TX, LED_ACK, ARG_TX, ARG_ACK
  } state_t;

  typedef enum logic [1:0] {STEP_REQ, STEP_STROBE, STEP_DRAIN} step_t;

  localparam int          RW        = $clog2(MAX_RETRY + 2);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYCLES - 1);

  state_t        state, state_n;
  step_t         step, step_n;
  logic [RW-1:0] retry_cnt, retry_n;
  logic [31:0]   to_cnt, to_n;
  logic [2:0]    led_lat, led_n;
  logic [7:0]    txd_n;
  logic          wd_n, err_n, done_n;

  logic [7:0] tx_byte;
  state_t     ack_state, resend_state, acked_state;
  logic       is_ack, timed_out, rx_fa, rx_fe, rx_aa;

  assign rx_fa     = read_data && (rx_data == 8'hFA);
  assign rx_fe     = read_data && (rx_data == 8'hFE);
  assign rx_aa     = read_data && (rx_data == 8'hAA);
  assign timed_out = (to_cnt == TO_LAST);
  assign is_ack    = (state == INIT_ACK) || (state == LED_ACK) || (state == ARG_ACK);
  assign cmd_busy  = (state != IDLE);

  // Per-command routing: byte to send, where to wait, where a resend or an ack leads.
  always_comb begin
    tx_byte      = 8'hFF;
    ack_state    = INIT_ACK;
    resend_state = INIT_TX;
    acked_state  = INIT_BAT;
    case (state)
      LED_TX, LED_ACK: begin
        tx_byte      = 8'hED;
        ack_state    = LED_ACK;
        resend_state = LED_TX;
        acked_state  = ARG_TX;
      end
      ARG_TX, ARG_ACK: begin
        tx_byte      = {5'b0, led_lat};
        ack_state    = ARG_ACK;
        resend_state = ARG_TX;
        acked_state  = IDLE;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    retry_n = retry_cnt;
    to_n    = '0;
    led_n   = led_lat;
    wd_n    = 1'b0;
    txd_n   = tx_data;
    err_n   = cmd_err;
    done_n  = init_done;
    case (state)
      INIT_TX, LED_TX, ARG_TX: begin
        if (err) begin
          err_n   = 1'b1;
          state_n = IDLE;
          step_n  = STEP_REQ;
          retry_n = '0;
        end else begin
          case (step)
            STEP_REQ: if (!busy) begin
              wd_n   = 1'b1;
              txd_n  = tx_byte;
              step_n = STEP_STROBE;
            end
            // the interface sees the strobe one edge later, so skip a cycle before watching busy
            STEP_STROBE: step_n = STEP_DRAIN;
            default: if (!busy) begin
              state_n = ack_state;
              step_n  = STEP_REQ;
            end
          endcase
        end
      end
      INIT_ACK, LED_ACK, ARG_ACK: begin
        to_n = to_cnt + 32'd1;
        if (err) begin
          err_n   = 1'b1;
          state_n = IDLE;
          retry_n = '0;
        end else if (rx_fa) begin
          state_n = acked_state;
          retry_n = '0;
          to_n    = '0;
        end else if (rx_fe) begin
          to_n = '0;
          if (retry_cnt == RETRY_MAX) begin
            err_n   = 1'b1;
            state_n = IDLE;
            retry_n = '0;
          end else begin
            state_n = resend_state;
            retry_n = retry_cnt + RW'(1);
          end
        end else if (timed_out) begin
          err_n   = 1'b1;
          state_n = IDLE;
          retry_n = '0;
        end
      end
      INIT_BAT: begin
        to_n = to_cnt + 32'd1;
        if (err || (timed_out && !rx_aa)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else if (rx_aa) begin
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: begin
        if (led_req) begin
          led_n   = led_val;
          state_n = LED_TX;
          step_n  = STEP_REQ;
          retry_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= INIT_TX;
      step       <= STEP_REQ;
      retry_cnt  <= '0;
      to_cnt     <= '0;
      led_lat    <= 3'b0;
      write_data <= 1'b0;
      tx_data    <= 8'h00;
      cmd_err    <= 1'b0;
      init_done  <= 1'b0;
    end else begin
      state      <= state_n;
      step       <= step_n;
      retry_cnt  <= retry_n;
      to_cnt     <= to_n;
      led_lat    <= led_n;
      write_data <= wd_n;
      tx_data    <= txd_n;
      cmd_err    <= err_n;
      init_done  <= done_n;
    end
  end

  // Replies the command FSM is waiting for are swallowed; everything else is keyboard traffic.
  logic consumed, key_byte, repeat_make, ext_flag, brk_flag;

  assign consumed = read_data &&
                    ((is_ack && (rx_data == 8'hFA || rx_data == 8'hFE)) ||
                     (state == INIT_BAT && rx_data == 8'hAA));
  assign key_byte = read_data && !consumed && (rx_data != 8'hE0) && (rx_data != 8'hF0);

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_make;
  logic       last_vld;

  assign repeat_make = last_vld && !brk_flag && ({ext_flag, rx_data} == last_make);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_make <= '0;
      last_vld  <= 1'b0;
    end else if (key_byte) begin
      if (brk_flag) begin
        if ({ext_flag, rx_data} == last_make) last_vld <= 1'b0;
      end else begin
        last_vld  <= 1'b1;
        last_make <= {ext_flag, rx_data};
      end
    end
  end
`else
  assign repeat_make = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_valid <= 1'b0;
      key_code  <= 8'h00;
      key_ext   <= 1'b0;
      key_break <= 1'b0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
    end else begin
      key_valid <= key_byte && !repeat_make;
      if (read_data && !consumed) begin
        if (rx_data == 8'hE0) begin
          ext_flag <= 1'b1;
        end else if (rx_data == 8'hF0) begin
          brk_flag <= 1'b1;
        end else begin
          ext_flag <= 1'b0;
          brk_flag <= 1'b0;
          if (!repeat_make) begin
            key_code  <= rx_data;
            key_ext   <= ext_flag;
            key_break <= brk_flag;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed bench for ps2_key_sequencer with a small busy-responding PS/2 interface model.
module tb_ps2_key_sequencer;

  logic       clk, reset, read_data, busy, err, led_req;
  logic [7:0] rx_data, tx_data, key_code;
  logic [2:0] led_val;
  logic       write_data, key_valid, key_ext, key_break, init_done, cmd_busy, cmd_err;

  int tests_run = 0;
  int tests_failed = 0;
  int wr_cnt = 0;
  int key_cnt = 0;
  int busy_left = 0;
  logic [7:0] tx_log[$];

  ps2_key_sequencer #(.TIMEOUT_CYCLES(100), .MAX_RETRY(3)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .read_data(read_data), .busy(busy),
    .err(err), .tx_data(tx_data), .write_data(write_data), .led_req(led_req),
    .led_val(led_val), .key_valid(key_valid), .key_code(key_code), .key_ext(key_ext),
    .key_break(key_break), .init_done(init_done), .cmd_busy(cmd_busy), .cmd_err(cmd_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Interface model: each transmit strobe holds busy high for three cycles.
  initial begin
    busy = 1'b0;
    forever begin
      @(negedge clk);
      if (key_valid) key_cnt++;
      if (write_data) begin
        wr_cnt++;
        tx_log.push_back(tx_data);
        busy = 1'b1;
        busy_left = 3;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) busy = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    read_data = 1'b1;
    @(negedge clk);
    read_data = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic wait_write(input int target);
    for (int i = 0; i < 200 && wr_cnt < target; i++) @(posedge clk);
    tests_run++;
    if (wr_cnt < target) begin
      tests_failed++;
      $display("FAIL wait_write: writes=%0d required=%0d", wr_cnt, target);
    end
  endtask

  // Returns on the edge where the FSM leaves its transmit state.
  task automatic wait_drain();
    for (int i = 0; i < 50 && busy; i++) @(posedge clk);
    tests_run++;
    if (busy) begin
      tests_failed++;
      $display("FAIL wait_drain: busy=%b required=0", busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; read_data = 1'b0; rx_data = 8'h00; err = 1'b0;
    led_req = 1'b0; led_val = 3'b000;
    settle(3);
    tests_run++; if (write_data !== 1'b0) begin tests_failed++; $display("FAIL rst_write_data: got %b exp 0", write_data); end
    tests_run++; if (tx_data !== 8'h00) begin tests_failed++; $display("FAIL rst_tx_data: got %h exp 00", tx_data); end
    tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_key_valid: got %b exp 0", key_valid); end
    tests_run++; if (key_code !== 8'h00) begin tests_failed++; $display("FAIL rst_key_code: got %h exp 00", key_code); end
    tests_run++; if ({key_ext, key_break} !== 2'b00) begin tests_failed++; $display("FAIL rst_flags: got %b exp 00", {key_ext, key_break}); end
    tests_run++; if (init_done !== 1'b0) begin tests_failed++; $display("FAIL rst_init_done: got %b exp 0", init_done); end
    tests_run++; if (cmd_busy !== 1'b1) begin tests_failed++; $display("FAIL rst_cmd_busy: got %b exp 1", cmd_busy); end
    tests_run++; if (cmd_err !== 1'b0) begin tests_failed++; $display("FAIL rst_cmd_err: got %b exp 0", cmd_err); end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests_run++; if ({write_data, key_valid} !== 2'b00) begin tests_failed++; $display("FAIL release_strobes: got %b exp 00", {write_data, key_valid}); end
  endtask

  task automatic test_init();
    wait_write(1);
    tests_run++; if (tx_data !== 8'hFF) begin tests_failed++; $display("FAIL init_tx: got %h exp FF", tx_data); end
    wait_drain();
    send_byte(8'hFA);
    settle(2);
    tests_run++; if ({init_done, cmd_busy} !== 2'b01) begin tests_failed++; $display("FAIL init_mid: got %b exp 01", {init_done, cmd_busy}); end
    send_byte(8'hAA);
    settle(2);
    tests_run++; if (init_done !== 1'b1) begin tests_failed++; $display("FAIL init_done: got %b exp 1", init_done); end
    tests_run++; if (cmd_busy !== 1'b0) begin tests_failed++; $display("FAIL init_cmd_busy: got %b exp 0", cmd_busy); end
    tests_run++; if (cmd_err !== 1'b0) begin tests_failed++; $display("FAIL init_cmd_err: got %b exp 0", cmd_err); end
    tests_run++; if (wr_cnt !== 1) begin tests_failed++; $display("FAIL init_writes: got %0d exp 1", wr_cnt); end
    tests_run++; if (key_cnt !== 0) begin tests_failed++; $display("FAIL init_no_keys: got %0d exp 0", key_cnt); end
  endtask

  task automatic test_decode();
    int k0;
    k0 = key_cnt;
    send_byte(8'hE0);
    send_byte(8'hF0);
    settle(2);
    tests_run++; if (key_cnt !== k0) begin tests_failed++; $display("FAIL prefix_events: got %0d exp %0d", key_cnt, k0); end
    send_byte(8'h75);
    settle(2);
    tests_run++; if (key_cnt !== k0 + 1) begin tests_failed++; $display("FAIL ext_break_events: got %0d exp %0d", key_cnt, k0 + 1); end
    tests_run++; if ({key_ext, key_break, key_code} !== {2'b11, 8'h75}) begin tests_failed++; $display("FAIL ext_break_key: got %b %h exp 11 75", {key_ext, key_break}, key_code); end
    @(negedge clk);
    rx_data = 8'h34; read_data = 1'b1;
    @(posedge clk); #1;
    tests_run++; if ({key_valid, key_code} !== {1'b1, 8'h34}) begin tests_failed++; $display("FAIL latency: got %b %h exp 1 34", key_valid, key_code); end
    @(negedge clk);
    read_data = 1'b0; rx_data = 8'h00;
    @(posedge clk); #1;
    tests_run++; if (key_valid !== 1'b0) begin tests_failed++; $display("FAIL pulse_width: got %b exp 0", key_valid); end
    tests_run++; if ({key_ext, key_break} !== 2'b00) begin tests_failed++; $display("FAIL flags_cleared: got %b exp 00", {key_ext, key_break}); end
  endtask

  task automatic test_typematic();
    int k0, exp_n;
`ifdef PS2_TYPEMATIC_FILTER_EN
    exp_n = 3;
`else
    exp_n = 4;
`endif
    k0 = key_cnt;
    send_byte(8'h1C);
    send_byte(8'h1C);
    send_byte(8'hF0);
    send_byte(8'h1C);
    send_byte(8'h1C);
    settle(2);
    tests_run++; if (key_cnt - k0 !== exp_n) begin tests_failed++; $display("FAIL typematic_events: got %0d exp %0d", key_cnt - k0, exp_n); end
    tests_run++; if ({key_break, key_code} !== {1'b0, 8'h1C}) begin tests_failed++; $display("FAIL typematic_last: got %b %h exp 0 1C", key_break, key_code); end
  endtask

  task automatic test_led();
    int w0, k0;
    w0 = wr_cnt; k0 = key_cnt;
    @(negedge clk); led_val = 3'b101; led_req = 1'b1;
    @(negedge clk); led_req = 1'b0; led_val = 3'b010;
    wait_write(w0 + 1);
    tests_run++; if (tx_data !== 8'hED) begin tests_failed++; $display("FAIL led_cmd: got %h exp ED", tx_data); end
    tests_run++; if (cmd_busy !== 1'b1) begin tests_failed++; $display("FAIL led_busy: got %b exp 1", cmd_busy); end
    wait_drain();
    @(negedge clk); led_val = 3'b111; led_req = 1'b1;
    @(negedge clk); led_req = 1'b0;
    send_byte(8'hFA);
    wait_write(w0 + 2);
    tests_run++; if (tx_data !== 8'h05) begin tests_failed++; $display("FAIL led_arg: got %h exp 05", tx_data); end
    wait_drain();
    send_byte(8'hFA);
    settle(12);
    tests_run++; if ({cmd_busy, cmd_err} !== 2'b00) begin tests_failed++; $display("FAIL led_done: got %b exp 00", {cmd_busy, cmd_err}); end
    tests_run++; if (wr_cnt !== w0 + 2) begin tests_failed++; $display("FAIL led_dropped_req: got %0d exp %0d", wr_cnt, w0 + 2); end
    tests_run++; if (key_cnt !== k0) begin tests_failed++; $display("FAIL led_no_keys: got %0d exp %0d", key_cnt, k0); end
  endtask

  task automatic test_retry();
    int w0, k0;
    w0 = wr_cnt; k0 = key_cnt;
    @(negedge clk); led_val = 3'b001; led_req = 1'b1;
    @(negedge clk); led_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_write(w0 + i + 1);
      tests_run++; if ({cmd_err, tx_data} !== {1'b0, 8'hED}) begin tests_failed++; $display("FAIL retry_%0d: got %b %h exp 0 ED", i, cmd_err, tx_data); end
      wait_drain();
      send_byte(8'hFE);
    end
    settle(8);
    tests_run++; if ({cmd_err, cmd_busy} !== 2'b10) begin tests_failed++; $display("FAIL retry_exhaust: got %b exp 10", {cmd_err, cmd_busy}); end
    tests_run++; if (wr_cnt !== w0 + 4) begin tests_failed++; $display("FAIL retry_writes: got %0d exp %0d", wr_cnt, w0 + 4); end
    tests_run++; if (key_cnt !== k0) begin tests_failed++; $display("FAIL retry_no_keys: got %0d exp %0d", key_cnt, k0); end
  endtask

  task automatic test_abort_timeout();
    int w0;
    w0 = wr_cnt;
    @(negedge clk); led_val = 3'b011; led_req = 1'b1;
    @(negedge clk); led_req = 1'b0;
    wait_write(w0 + 1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++; if ({cmd_busy, cmd_err, init_done, write_data} !== 4'b1000) begin tests_failed++; $display("FAIL abort_state: got %b exp 1000", {cmd_busy, cmd_err, init_done, write_data}); end
    repeat (6) @(negedge clk);
    reset = 1'b1;
    w0 = wr_cnt;
    wait_write(w0 + 1);
    tests_run++; if (tx_data !== 8'hFF) begin tests_failed++; $display("FAIL restart_tx: got %h exp FF", tx_data); end
    wait_drain();
    repeat (99) @(posedge clk);
    #1;
    tests_run++; if (cmd_err !== 1'b0) begin tests_failed++; $display("FAIL timeout_early: got %b exp 0", cmd_err); end
    @(posedge clk);
    #1;
    tests_run++; if (cmd_err !== 1'b1) begin tests_failed++; $display("FAIL timeout_set: got %b exp 1", cmd_err); end
    tests_run++; if ({init_done, cmd_busy} !== 2'b00) begin tests_failed++; $display("FAIL timeout_state: got %b exp 00", {init_done, cmd_busy}); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_decode();
    test_typematic();
    test_led();
    test_retry();
    test_abort_timeout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/ps2_key_sequencer.md
PS2_KEY_SEQUENCER -- requirements
Module: ps2_key_sequencer

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 2000000, clk cycles allowed to wait for any device response byte.
REQ-002 Parameter: MAX_RETRY, default 3, resend attempts allowed per command byte after an 0xFE reply.
REQ-003 Clocking is decided: one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  system clock, sole clock domain.
REQ-005 reset  in  1  asynchronous reset, active-low (0 = reset asserted).
REQ-006 rx_data  in  8  byte received from the PS/2 interface; valid only while read_data=1.
REQ-007 read_data  in  1  one-cycle strobe marking a received byte.
REQ-008 busy  in  1  PS/2 interface transmit/receive in progress.
REQ-009 err  in  1  one-cycle strobe marking a PS/2 interface transmit error.
REQ-010 tx_data  out  8  byte to transmit to the device; held stable from write_data until busy falls.
REQ-011 write_data  out  1  one-cycle transmit request strobe.
REQ-012 led_req  in  1  one-cycle request to update keyboard LEDs.
REQ-013 led_val  in  3  {caps, num, scroll}; sampled in the cycle led_req=1.
REQ-014 key_valid  out  1  one-cycle strobe marking a decoded key event.
REQ-015 key_code  out  8  scan code of the event; held until the next event.
REQ-016 key_ext  out  1  event was preceded by 0xE0.
REQ-017 key_break  out  1  event is a release (preceded by 0xF0).
REQ-018 init_done  out  1  device reset handshake completed successfully.
REQ-019 cmd_busy  out  1  command sequence in progress; led_req ignored while 1.
REQ-020 cmd_err  out  1  sticky; set on timeout, err strobe or retry exhaustion.

Function
REQ-021 Command FSM states: INIT_TX, INIT_ACK, INIT_BAT, IDLE, LED_TX, LED_ACK, ARG_TX, ARG_ACK.
REQ-022 Transmit rule: write_data pulses exactly one cycle, only when busy=0; the FSM then waits for busy to fall before awaiting a reply.
REQ-023 INIT_TX sends 0xFF; INIT_ACK awaits 0xFA; INIT_BAT awaits 0xAA, then init_done=1 and the FSM enters IDLE.
REQ-024 In IDLE, led_req=1 latches led_val and enters LED_TX (sends 0xED); LED_ACK awaits 0xFA; ARG_TX sends {5'b0,led_val}; ARG_ACK awaits 0xFA, then the FSM returns to IDLE.
REQ-025 cmd_busy=1 in every state except IDLE.
REQ-026 Reply 0xFE in any *_ACK state retransmits the same byte; after MAX_RETRY resends, the next 0xFE sets cmd_err and goes to IDLE.
REQ-027 A 32-bit timeout counter clears on entry to each *_ACK/INIT_BAT state; reaching TIMEOUT_CYCLES sets cmd_err and goes to IDLE (init_done stays 0 if in INIT).
REQ-028 err=1 during any *_TX or ACK wait sets cmd_err and goes to IDLE.
REQ-029 Bytes consumed by the command FSM (0xFA, 0xAA, 0xFE while awaiting them) never produce key events.
REQ-030 Decoder: 0xE0 sets the ext flag, 0xF0 sets the break flag; any other byte in IDLE produces key_valid with key_code=byte and the flags, then both flags clear; latency one cycle after read_data.
REQ-031 Bytes arriving in non-IDLE states other than expected replies are decoded as keys (keyboard traffic is not blocked).
REQ-032 led_req arriving while cmd_busy=1 is dropped, not queued.
REQ-033 key_valid and write_data are never asserted in the same cycle as reset deassertion.

Reset
REQ-034 Reset asserted: FSM to INIT_TX; write_data=0, tx_data=0x00, key_valid=0, key_code=0x00, key_ext=0, key_break=0, init_done=0, cmd_busy=1, cmd_err=0; flags, retry and timeout counters cleared.
REQ-035 Reset asserted mid-sequence aborts it immediately; the init sequence restarts after deassertion.

Configuration
REQ-036 Macro PS2_TYPEMATIC_FILTER_EN defined: a make event whose {key_ext,key_code} equals the last reported make with no intervening break of it is suppressed (no key_valid).
REQ-037 Macro PS2_TYPEMATIC_FILTER_EN undefined: every make byte, including auto-repeat, produces key_valid.

Verification
REQ-038 Reset release; reply 0xFA then 0xAA -> tx_data=0xFF with one write_data pulse, init_done=1, cmd_busy=0, cmd_err=0.
REQ-039 Idle; rx bytes 0xE0,0xF0,0x75 -> one key_valid, key_code=0x75, key_ext=1, key_break=1; no events for the prefixes.
REQ-040 Idle; led_req with led_val=3'b101, replies 0xFA,0xFA -> transmits 0xED then 0x05; cmd_busy returns to 0.
REQ-041 LED_ACK receives 0xFE four times (MAX_RETRY=3) -> 0xED sent four times total, cmd_err=1, FSM in IDLE.
REQ-042 INIT_ACK with no reply, TIMEOUT_CYCLES=100 -> cmd_err=1 on cycle 100, init_done=0.
REQ-043 With PS2_TYPEMATIC_FILTER_EN: bytes 0x1C,0x1C,0xF0,0x1C,0x1C -> three key_valid (make, break, make); without the macro -> four.
